// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage_if
//  Brief    : Fetch-side and execute-side bundle for the decode stage.
//             'slave' is the decode stage's view, 'master' the environment's.
//  Revision : 1.0  initial release
// ============================================================================
interface id_stage_if #(
    parameter int PC_W = 5,
    parameter int XLEN = 32
);
    // fetch -> decode
    logic [PC_W-1:0] pc_present;
    logic [XLEN-1:0] inst;
    logic            if_valid;
    logic            id_ready;
    // decode -> fetch redirect
    logic            branch_sel;
    logic [PC_W-1:0] branch_imp;
    // decode -> execute
    logic            ex_ready;
    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport slave (
        input  pc_present, inst, if_valid, ex_ready,
        output id_ready, branch_sel, branch_imp, id_valid, id_pc,
               opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );

    modport master (
        output pc_present, inst, if_valid, ex_ready,
        input  id_ready, branch_sel, branch_imp, id_valid, id_pc,
               opcode, rd, funct3, rs1, rs2, funct7, imm, illegal
    );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_stage
//  Brief    : RV32I instruction-decode stage. Holds one instruction in an
//             IF/ID register, decodes fields and immediate, and redirects
//             fetch for JAL and backward conditional branches (static
//             backward-taken prediction) for exactly one cycle.
//  Revision : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter int PC_W = 5,
    parameter int XLEN = 32
) (
    input  wire logic   clk,
    input  wire logic   reset,
    id_stage_if.slave   bus
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;

    typedef enum logic [0:0] {
        S_RUN      = 1'b0,
        S_REDIRECT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic [PC_W-1:0]   bimp_q, bimp_d;

    logic              w_id_ready;
    logic              w_capture;
    logic              w_in_redir;
    logic [XLEN-1:0]   w_imm;
    logic              w_legal;
    logic [PC_W-1:0]   w_target;
    logic [6:0]        w_op_q;
    logic [6:0]        w_op_in;

    assign w_op_q  = inst_q[6:0];
    assign w_op_in = bus.inst[6:0];

    // Immediate generation and opcode legality from the held instruction
    always_comb begin
        w_imm   = '0;
        w_legal = 1'b1;
        case (w_op_q)
            c_OP_LOAD, c_OP_IMM, c_OP_JALR, c_OP_SYSTEM:
                w_imm = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
            c_OP_STORE:
                w_imm = {{(XLEN-12){inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            c_OP_BRANCH:
                w_imm = {{(XLEN-13){inst_q[31]}}, inst_q[31], inst_q[7],
                         inst_q[30:25], inst_q[11:8], 1'b0};
            c_OP_LUI, c_OP_AUIPC:
                w_imm = {inst_q[31:12], 12'b0};
            c_OP_JAL:
                w_imm = {{(XLEN-21){inst_q[31]}}, inst_q[31], inst_q[19:12],
                         inst_q[20], inst_q[30:21], 1'b0};
            c_OP_REG:
                w_imm = '0;
            default: begin
                w_imm   = '0;
                w_legal = 1'b0;
            end
        endcase
    end

    // During REDIRECT the stage swallows the wrong-path fetch word, so it is
    // always ready; otherwise ready whenever the holding register can drain.
    assign w_id_ready = (state_q == S_REDIRECT) || !valid_q || bus.ex_ready;
    assign w_capture  = (state_q == S_RUN) && bus.if_valid && w_id_ready;
    // JAL and branch opcodes are always legal, so only the sign bit matters
    // for the branch case.
    assign w_in_redir = (w_op_in == c_OP_JAL) ||
                        ((w_op_in == c_OP_BRANCH) && bus.inst[XLEN-1]);
    // Truncating add: the target wraps modulo 2^PC_W.
    assign w_target   = pc_q + w_imm[PC_W-1:0];

    // Next-state logic for the pipeline register and the redirect FSM
    always_comb begin
        state_d = S_RUN;
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        bimp_d  = bimp_q;

        if (w_capture) begin
            valid_d = 1'b1;
            pc_d    = bus.pc_present;
            inst_d  = bus.inst;
        end else if (valid_q && bus.ex_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                if (w_capture && w_in_redir) begin
                    state_d = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                bimp_d  = w_target;
                state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    // State registers with synchronous reset overriding capture and redirect
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            bimp_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            bimp_q  <= bimp_d;
        end
    end

    assign bus.id_ready   = w_id_ready;
    assign bus.id_valid   = valid_q;
    assign bus.id_pc      = pc_q;
    assign bus.opcode     = inst_q[6:0];
    assign bus.rd         = inst_q[11:7];
    assign bus.funct3     = inst_q[14:12];
    assign bus.rs1        = inst_q[19:15];
    assign bus.rs2        = inst_q[24:20];
    assign bus.funct7     = inst_q[31:25];
    assign bus.imm        = w_imm;
    assign bus.illegal    = valid_q && !w_legal;
    assign bus.branch_sel = (state_q == S_REDIRECT);
    assign bus.branch_imp = (state_q == S_REDIRECT) ? w_target : bimp_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_stage
//  Brief    : Self-checking bench for id_stage: behavioural model compared
//             every cycle, plus directed vectors with literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_stage;
    localparam int PC_W = 5;
    localparam int XLEN = 32;

    localparam logic [31:0] c_ADDI5   = 32'h00A00293; // addi x5,x0,10
    localparam logic [31:0] c_ADDI6   = 32'h00100313; // addi x6,x0,1
    localparam logic [31:0] c_JAL_M8  = 32'hFF9FF0EF; // jal x1,-8
    localparam logic [31:0] c_BEQ_M4  = 32'hFE000EE3; // beq x0,x0,-4
    localparam logic [31:0] c_BEQ_P8  = 32'h00000463; // beq x0,x0,+8
    localparam logic [31:0] c_JALR_M8 = 32'hFF8080E7; // jalr x1,-8(x1)
    localparam logic [31:0] c_BAD     = 32'hFFFFFFFF; // opcode 0x7F
    localparam logic [31:0] c_LUI     = 32'h123452B7; // lui x5,0x12345
    localparam logic [31:0] c_SW      = 32'hFE512E23; // sw x5,-4(x2)

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if #(.PC_W(PC_W), .XLEN(XLEN)) bus ();

    id_stage #(.PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] m_imm(input logic [31:0] i);
        int s;
        int v;
        s = i;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = s >>> 20;
            7'h23: v = (s >>> 25) * 32 + int'(i[11:7]);
            7'h63: v = (s >>> 31) * 4096 + int'(i[7]) * 2048
                       + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = s & 32'hFFFFF000;
            7'h6F: v = (s >>> 31) * (1 << 20) + int'(i[19:12]) * 4096
                       + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic logic m_is_illegal(input logic [6:0] op);
        return !(op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63,
                            7'h37, 7'h17, 7'h6F, 7'h33});
    endfunction

    function automatic logic m_predict_taken(input logic [31:0] i);
        return (i[6:0] == 7'h6F) || (i[6:0] == 7'h63 && i[31]);
    endfunction

    logic        m_valid = 1'b0;
    logic [4:0]  m_pc    = '0;
    logic [31:0] m_inst  = '0;
    logic        m_redir = 1'b0;
    logic [4:0]  m_bimp  = '0;

    // Model update on each active edge
    always @(posedge clk) begin : model_upd
        logic        rdy;
        logic        cap;
        logic [31:0] im;
        logic [4:0]  tgt;
        rdy = m_redir || !m_valid || bus.ex_ready;
        cap = !m_redir && bus.if_valid && rdy;
        im  = m_imm(m_inst);
        tgt = m_pc + im[4:0];
        if (reset) begin
            m_valid <= 1'b0;
            m_pc    <= '0;
            m_inst  <= '0;
            m_redir <= 1'b0;
            m_bimp  <= '0;
        end else begin
            if (m_redir) m_bimp <= tgt;
            m_redir <= cap && m_predict_taken(bus.inst);
            if (cap) begin
                m_valid <= 1'b1;
                m_pc    <= bus.pc_present;
                m_inst  <= bus.inst;
            end else if (m_valid && bus.ex_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every output against the model mid-cycle
    always @(negedge clk) begin : cmp
        logic [31:0] e_imm;
        logic [4:0]  tgt;
        e_imm = m_imm(m_inst);
        tgt   = m_pc + e_imm[4:0];
        chk("m_id_ready",   32'(bus.id_ready),   32'(m_redir || !m_valid || bus.ex_ready));
        chk("m_id_valid",   32'(bus.id_valid),   32'(m_valid));
        chk("m_id_pc",      32'(bus.id_pc),      32'(m_pc));
        chk("m_opcode",     32'(bus.opcode),     32'(m_inst[6:0]));
        chk("m_rd",         32'(bus.rd),         32'(m_inst[11:7]));
        chk("m_funct3",     32'(bus.funct3),     32'(m_inst[14:12]));
        chk("m_rs1",        32'(bus.rs1),        32'(m_inst[19:15]));
        chk("m_rs2",        32'(bus.rs2),        32'(m_inst[24:20]));
        chk("m_funct7",     32'(bus.funct7),     32'(m_inst[31:25]));
        chk("m_imm",        bus.imm,             e_imm);
        chk("m_illegal",    32'(bus.illegal),    32'(m_valid && m_is_illegal(m_inst[6:0])));
        chk("m_branch_sel", 32'(bus.branch_sel), 32'(m_redir));
        chk("m_branch_imp", 32'(bus.branch_imp), 32'(m_redir ? tgt : m_bimp));
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic r, input logic iv, input logic [4:0] pc,
                         input logic [31:0] ins, input logic er);
        #1;
        reset          = r;
        bus.if_valid   = iv;
        bus.pc_present = pc;
        bus.inst       = ins;
        bus.ex_ready   = er;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // 1. reset with if_valid high
        drive(1'b1, 1'b1, 5'd4, c_ADDI5, 1'b1);
        step();
        step();
        chk("rst_id_valid",   32'(bus.id_valid),   32'd0);
        chk("rst_id_pc",      32'(bus.id_pc),      32'd0);
        chk("rst_opcode",     32'(bus.opcode),     32'd0);
        chk("rst_imm",        bus.imm,             32'd0);
        chk("rst_illegal",    32'(bus.illegal),    32'd0);
        chk("rst_branch_sel", 32'(bus.branch_sel), 32'd0);
        chk("rst_branch_imp", 32'(bus.branch_imp), 32'd0);
        drive(1'b0, 1'b0, 5'd4, c_ADDI5, 1'b1);
        step();
        chk("idle_id_valid", 32'(bus.id_valid), 32'd0);

        // 2. single capture
        drive(1'b0, 1'b1, 5'd4, c_ADDI5, 1'b1);
        step();
        chk("cap_id_valid",   32'(bus.id_valid),   32'd1);
        chk("cap_id_pc",      32'(bus.id_pc),      32'd4);
        chk("cap_opcode",     32'(bus.opcode),     32'h13);
        chk("cap_rd",         32'(bus.rd),         32'd5);
        chk("cap_rs1",        32'(bus.rs1),        32'd0);
        chk("cap_funct3",     32'(bus.funct3),     32'd0);
        chk("cap_imm",        bus.imm,             32'd10);
        chk("cap_branch_sel", 32'(bus.branch_sel), 32'd0);

        // 3. stall three cycles, then release with capture in the same cycle
        drive(1'b0, 1'b1, 5'd6, c_ADDI6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_id_ready", 32'(bus.id_ready), 32'd0);
            chk("stall_id_pc",    32'(bus.id_pc),    32'd4);
            chk("stall_imm",      bus.imm,           32'd10);
        end
        drive(1'b0, 1'b1, 5'd6, c_ADDI6, 1'b1);
        #1;
        chk("release_id_ready", 32'(bus.id_ready), 32'd1);
        step();
        chk("release_id_pc",    32'(bus.id_pc),    32'd6);
        chk("release_imm",      bus.imm,           32'd1);

        // 4. JAL redirect, wrong-path word squashed even with ex_ready low
        drive(1'b0, 1'b1, 5'd8, c_JAL_M8, 1'b1);
        step();
        chk("jal_branch_sel", 32'(bus.branch_sel), 32'd1);
        chk("jal_branch_imp", 32'(bus.branch_imp), 32'd0);
        chk("jal_imm",        bus.imm,             32'hFFFFFFF8);
        chk("jal_id_pc",      32'(bus.id_pc),      32'd8);
        drive(1'b0, 1'b1, 5'd10, c_ADDI5, 1'b0);
        #1;
        chk("jal_squash_ready", 32'(bus.id_ready), 32'd1);
        step();
        chk("jal_after_sel",   32'(bus.branch_sel), 32'd0);
        chk("jal_after_pc",    32'(bus.id_pc),      32'd8);
        chk("jal_after_valid", 32'(bus.id_valid),   32'd1);
        chk("jal_after_imp",   32'(bus.branch_imp), 32'd0);
        drive(1'b0, 1'b0, 5'd10, c_ADDI5, 1'b1);
        step();
        chk("drain_id_valid", 32'(bus.id_valid), 32'd0);

        // 5. backward branch predicted taken, forward branch not
        drive(1'b0, 1'b1, 5'd12, c_BEQ_M4, 1'b1);
        step();
        chk("beqb_branch_sel", 32'(bus.branch_sel), 32'd1);
        chk("beqb_branch_imp", 32'(bus.branch_imp), 32'd8);
        chk("beqb_imm",        bus.imm,             32'hFFFFFFFC);
        drive(1'b0, 1'b1, 5'd14, c_BEQ_P8, 1'b1);
        step();
        chk("beqb_sq_sel",   32'(bus.branch_sel), 32'd0);
        chk("beqb_sq_valid", 32'(bus.id_valid),   32'd0);
        step();
        chk("beqf_id_pc",      32'(bus.id_pc),      32'd14);
        chk("beqf_imm",        bus.imm,             32'd8);
        chk("beqf_branch_sel", 32'(bus.branch_sel), 32'd0);
        step();
        chk("beqf_again_sel",  32'(bus.branch_sel), 32'd0);

        // 6. wrap-around target, back-to-back redirect, reset mid-redirect
        drive(1'b0, 1'b1, 5'd2, c_JAL_M8, 1'b1);
        step();
        chk("wrap_branch_sel", 32'(bus.branch_sel), 32'd1);
        chk("wrap_branch_imp", 32'(bus.branch_imp), 32'd26);
        step();
        chk("wrap_sq_sel", 32'(bus.branch_sel), 32'd0);
        chk("wrap_sq_imp", 32'(bus.branch_imp), 32'd26);
        step();
        chk("b2b_branch_sel", 32'(bus.branch_sel), 32'd1);
        drive(1'b1, 1'b1, 5'd2, c_JAL_M8, 1'b1);
        step();
        chk("rstr_branch_sel", 32'(bus.branch_sel), 32'd0);
        chk("rstr_id_valid",   32'(bus.id_valid),   32'd0);
        chk("rstr_branch_imp", 32'(bus.branch_imp), 32'd0);

        // JALR backward never redirects
        drive(1'b0, 1'b1, 5'd16, c_JALR_M8, 1'b1);
        step();
        chk("jalr_imm",        bus.imm,             32'hFFFFFFF8);
        chk("jalr_branch_sel", 32'(bus.branch_sel), 32'd0);
        step();
        chk("jalr_again_sel",  32'(bus.branch_sel), 32'd0);

        // illegal opcode
        drive(1'b0, 1'b1, 5'd18, c_BAD, 1'b1);
        step();
        chk("bad_illegal", 32'(bus.illegal), 32'd1);
        chk("bad_imm",     bus.imm,          32'd0);

        // U-type and S-type immediates
        drive(1'b0, 1'b1, 5'd20, c_LUI, 1'b1);
        step();
        chk("bad_then_sel", 32'(bus.branch_sel), 32'd0);
        chk("lui_imm",      bus.imm,             32'h12345000);
        chk("lui_illegal",  32'(bus.illegal),    32'd0);
        drive(1'b0, 1'b1, 5'd22, c_SW, 1'b1);
        step();
        chk("sw_imm",    bus.imm,          32'hFFFFFFFC);
        chk("sw_rs2",    32'(bus.rs2),     32'd5);
        chk("sw_rs1",    32'(bus.rs1),     32'd2);
        chk("sw_funct3", 32'(bus.funct3),  32'd2);

        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        step();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
